// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Load/store unit with alignment and range checks. Sub-doubleword
//           stores are done by read-modify-write on a 64-bit data memory.
// Rev     : 1.0
// ============================================================================
module load_store_unit #(
  parameter int DEPTH = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGNED,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [63:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [63:0] MEM_ADDR,
  output logic [63:0] MEM_WR_DATA,
  input  logic [63:0] MEM_RD_DATA
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_word;
  logic [63:0] r_rsp_data;
  logic        r_err;

  logic        w_misaligned;
  logic        w_in_range;
  logic        w_legal;
  logic        w_accept;
  logic [5:0]  w_shift;
  logic [63:0] w_size_mask;
  logic [63:0] w_rd_shifted;
  logic [63:0] w_load_data;
  logic [63:0] w_merged;

  always_comb begin
    w_misaligned = 1'b0;
    case (REQ_SIZE)
      2'b01:   w_misaligned = REQ_ADDR[0];
      2'b10:   w_misaligned = |REQ_ADDR[1:0];
      2'b11:   w_misaligned = |REQ_ADDR[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_in_range = (REQ_ADDR[63:3] < 61'(DEPTH));
  assign w_legal    = !w_misaligned && w_in_range;
  assign w_accept   = (r_state == IDLE) && REQ_VALID;

  // Byte lane offset and size mask of the registered request
  assign w_shift = {r_addr[2:0], 3'b000};

  always_comb begin
    w_size_mask = '1;
    case (r_size)
      2'b00:   w_size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   w_size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   w_size_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_size_mask = '1;
    endcase
  end

  assign w_rd_shifted = MEM_RD_DATA >> w_shift;

  always_comb begin
    w_load_data = w_rd_shifted;
    case (r_size)
      2'b00:   w_load_data = {{56{r_signed & w_rd_shifted[7]}},  w_rd_shifted[7:0]};
      2'b01:   w_load_data = {{48{r_signed & w_rd_shifted[15]}}, w_rd_shifted[15:0]};
      2'b10:   w_load_data = {{32{r_signed & w_rd_shifted[31]}}, w_rd_shifted[31:0]};
      default: w_load_data = w_rd_shifted;
    endcase
  end

  // A doubleword store has a full mask and zero shift, so it reduces to r_wdata
  assign w_merged = (r_word & ~(w_size_mask << w_shift)) |
                    ((r_wdata & w_size_mask) << w_shift);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    REQ_READY   = 1'b0;
    RSP_VALID   = 1'b0;
    RSP_DATA    = '0;
    RSP_ERR     = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDR    = '0;
    MEM_WR_DATA = '0;
    case (r_state)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          if (!w_legal)                             w_next = RESP;
          else if (REQ_WRITE && REQ_SIZE == 2'b11)  w_next = WRITE;
          else                                      w_next = READ;
        end
      end
      READ: begin
        MEM_READ = 1'b1;
        MEM_ADDR = {3'b000, r_addr[63:3]};
        w_next   = r_write ? WRITE : RESP;
      end
      WRITE: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDR    = {3'b000, r_addr[63:3]};
        MEM_WR_DATA = w_merged;
        w_next      = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        RSP_DATA  = r_rsp_data;
        RSP_ERR   = r_err;
        MEM_ADDR  = {3'b000, r_addr[63:3]};
        if (RSP_READY) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write    <= REQ_WRITE;
        r_size     <= REQ_SIZE;
        r_signed   <= REQ_SIGNED;
        r_addr     <= REQ_ADDR;
        r_wdata    <= REQ_WDATA;
        r_word     <= '0;
        r_rsp_data <= '0;
        r_err      <= !w_legal;
      end
      if (r_state == READ) begin
        if (r_write) r_word     <= MEM_RD_DATA;
        else         r_rsp_data <= w_load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Directed scoreboard bench for load_store_unit with a memory model.
// Rev     : 1.0
// ============================================================================
module tb_load_store_unit;

  localparam int DEPTH = 64;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGNED;
  logic [63:0] REQ_ADDR;
  logic [63:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [63:0] RSP_DATA;
  logic        RSP_ERR;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [63:0] MEM_ADDR;
  logic [63:0] MEM_WR_DATA;
  logic [63:0] MEM_RD_DATA;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR), .MEM_WR_DATA(MEM_WR_DATA),
    .MEM_RD_DATA(MEM_RD_DATA)
  );

  always #5 CLK = ~CLK;

  // Data memory attached to the DUT, plus an independent reference image
  logic [63:0] mem     [0:DEPTH-1] = '{default: 64'h0};
  logic [63:0] ref_mem [0:DEPTH-1] = '{default: 64'h0};

  assign MEM_RD_DATA = mem[MEM_ADDR[5:0]];
  always @(posedge CLK) if (MEM_WRITE) mem[MEM_ADDR[5:0]] <= MEM_WR_DATA;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          idx;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int last_wr_idx = -1;
  logic [63:0] last_data;

  always @(posedge CLK) begin
    if (MEM_READ)  rd_cnt = rd_cnt + 1;
    if (MEM_WRITE) begin
      wr_cnt      = wr_cnt + 1;
      last_wr_idx = int'(MEM_ADDR[31:0]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1) chk("strobe_exclusive", 64'(MEM_READ & MEM_WRITE), 64'd0);
  end

  // Reference behaviour built byte by byte from the reference memory image
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] addr, input logic [63:0] wd, output exp_t e);
    int n;
    int off;
    int ix;
    logic [63:0] v;
    n   = 1 << sz;
    off = int'(addr[2:0]);
    ix  = int'(addr[8:3]);
    e.err  = ((off % n) != 0) || ((addr >> 3) >= 64'(DEPTH));
    e.data = 64'h0;
    e.idx  = ix;
    if (e.err) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0;
    end else if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[ix][8*(off+i) +: 8] = wd[8*i +: 8];
      e.lat = (sz == 2'b11) ? 2 : 3;
      e.nrd = (sz == 2'b11) ? 0 : 1;
      e.nwr = 1;
    end else begin
      v = 64'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[ix][8*(off+i) +: 8];
      if (sg && sz != 2'b11 && v[8*n-1])
        for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e.data = v;
      e.lat = 2; e.nrd = 1; e.nwr = 0;
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [63:0] addr,
                        input logic [63:0] wd, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    model(wr, sz, sg, addr, wd, e);
    sb.push_back(e);
    @(negedge CLK);
    chk({tag, "_req_ready"}, 64'(REQ_READY), 64'd1);
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_SIZE = sz; REQ_SIGNED = sg;
    REQ_ADDR = addr; REQ_WDATA = wd;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    rd_cnt = 0; wr_cnt = 0; last_wr_idx = -1;
    lat = 1;
    while (RSP_VALID !== 1'b1 && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    got = sb.pop_front();
    if (RSP_VALID !== 1'b1) begin
      tests++; fails++;
      $error("FAIL %s_timeout: observed=no response expected=response", tag);
    end else begin
      chk({tag, "_latency"}, 64'(lat), 64'(got.lat));
      chk({tag, "_rsp_data"}, RSP_DATA, got.data);
      chk({tag, "_rsp_err"}, 64'(RSP_ERR), 64'(got.err));
      last_data = RSP_DATA;
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        chk({tag, "_hold_valid"}, 64'(RSP_VALID), 64'd1);
        chk({tag, "_hold_data"}, RSP_DATA, got.data);
        chk({tag, "_hold_ready"}, 64'(REQ_READY), 64'd0);
      end
      @(negedge CLK);
      RSP_READY = 1'b1;
      @(posedge CLK);
      #1;
      RSP_READY = 1'b0;
      chk({tag, "_back_idle"}, 64'(REQ_READY), 64'd1);
      chk({tag, "_valid_drop"}, 64'(RSP_VALID), 64'd0);
    end
    chk({tag, "_mem_reads"}, 64'(rd_cnt), 64'(got.nrd));
    chk({tag, "_mem_writes"}, 64'(wr_cnt), 64'(got.nwr));
    if (got.nwr != 0) chk({tag, "_wr_index"}, 64'(last_wr_idx), 64'(got.idx));
  endtask

  initial begin
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_SIZE = 2'b00;
    REQ_SIGNED = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b0;
    last_data = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 64'(REQ_READY), 64'd1);
    chk("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("rst_rsp_err",   64'(RSP_ERR), 64'd0);
    chk("rst_rsp_data",  RSP_DATA, 64'd0);
    chk("rst_mem_strb",  64'({MEM_READ, MEM_WRITE}), 64'd0);
    chk("rst_mem_addr",  MEM_ADDR, 64'd0);
    chk("rst_mem_wdata", MEM_WR_DATA, 64'd0);
    RST_N = 1'b1;

    do_req("st_dw",    1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, 0);
    do_req("ld_dw",    1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0);
    chk("ld_dw_const", last_data, 64'h1122334455667788);
    do_req("st_b",     1'b1, 2'b00, 1'b0, 64'h13, 64'hAB, 0);
    do_req("ld_dw2",   1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0);
    chk("ld_dw2_const", last_data, 64'h11223344AB667788);

    do_req("st_msb",   1'b1, 2'b11, 1'b0, 64'h10, 64'h8000000000000000, 0);
    do_req("ld_ws",    1'b0, 2'b10, 1'b1, 64'h14, 64'h0, 0);
    chk("ld_ws_const", last_data, 64'hFFFFFFFF80000000);
    do_req("ld_wu",    1'b0, 2'b10, 1'b0, 64'h14, 64'h0, 0);
    chk("ld_wu_const", last_data, 64'h0000000080000000);

    do_req("err_half", 1'b0, 2'b01, 1'b0, 64'h11, 64'h0, 0);
    do_req("err_rng",  1'b0, 2'b11, 1'b0, 64'h200, 64'h0, 0);
    do_req("err_stb",  1'b1, 2'b00, 1'b0, 64'h200, 64'h5A, 0);
    do_req("err_stw",  1'b1, 2'b10, 1'b0, 64'h22, 64'h5A, 0);

    do_req("ld_bs_hold", 1'b0, 2'b00, 1'b1, 64'h17, 64'h0, 5);
    do_req("st_h",     1'b1, 2'b01, 1'b0, 64'h2A, 64'hFFFF_BEEF, 0);
    do_req("ld_hs",    1'b0, 2'b01, 1'b1, 64'h2A, 64'h0, 0);
    do_req("ld_hu",    1'b0, 2'b01, 1'b0, 64'h2A, 64'h0, 0);
    do_req("st_w_top", 1'b1, 2'b10, 1'b0, 64'h1FC, 64'h1234_5678_CAFE_F00D, 0);
    do_req("ld_dw_top", 1'b0, 2'b11, 1'b0, 64'h1F8, 64'h0, 0);

    // Reset pulse while a byte store sits in its read phase
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_SIZE = 2'b00; REQ_SIGNED = 1'b0;
    REQ_ADDR = 64'h10; REQ_WDATA = 64'h55;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    chk("abort_in_read", 64'(MEM_READ), 64'd1);
    wr_cnt = 0;
    RST_N = 1'b0;
    #1;
    chk("abort_req_ready", 64'(REQ_READY), 64'd1);
    chk("abort_rsp", 64'({RSP_VALID, RSP_ERR}), 64'd0);
    chk("abort_rsp_data", RSP_DATA, 64'd0);
    chk("abort_mem_strb", 64'({MEM_READ, MEM_WRITE}), 64'd0);
    chk("abort_mem_addr", MEM_ADDR, 64'd0);
    chk("abort_mem_wdata", MEM_WR_DATA, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("abort_no_write", 64'(wr_cnt), 64'd0);
    chk("abort_idle", 64'({REQ_READY, RSP_VALID}), 64'b10);
    chk("abort_mem_kept", mem[2], 64'h8000000000000000);
    do_req("ld_after_rst", 1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0);
    chk("ld_after_rst_const", last_data, 64'h8000000000000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH, default 64, gives the number of 64-bit doublewords in the attached data memory.
REQ-002 CLK  input  1  single clock; all state updates on posedge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 REQ_VALID  input  1  pipeline presents a memory request.
REQ-005 REQ_READY  output  1  unit can accept a request (IDLE only).
REQ-006 REQ_WRITE  input  1  1 = store, 0 = load.
REQ-007 REQ_SIZE  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-008 REQ_SIGNED  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 REQ_ADDR  input  64  byte address.
REQ-010 REQ_WDATA  input  64  store data, right-justified.
REQ-011 RSP_VALID  output  1  response available.
REQ-012 RSP_READY  input  1  consumer accepts the response.
REQ-013 RSP_DATA  output  64  load result; 0 for stores and errors.
REQ-014 RSP_ERR  output  1  request was misaligned or out of range.
REQ-015 MEM_READ  output  1  read strobe to data memory.
REQ-016 MEM_WRITE  output  1  write strobe; memory writes on the posedge where this is high.
REQ-017 MEM_ADDR  output  64  doubleword index = REQ_ADDR >> 3.
REQ-018 MEM_WR_DATA  output  64  full doubleword written.
REQ-019 MEM_RD_DATA  input  64  combinational read data, valid in the same cycle as MEM_READ.

Function
REQ-020 FSM states: IDLE, READ, WRITE, RESP; transitions occur only on posedge CLK.
REQ-021 In IDLE, REQ_READY=1; a request is accepted on a posedge with REQ_VALID=1, and all request fields are registered at that edge.
REQ-022 Alignment: the request is legal only if the low bits of REQ_ADDR are zero per size (none for byte, [0] for half, [1:0] for word, [2:0] for doubleword).
REQ-023 Range: the request is legal only if (REQ_ADDR >> 3) < DEPTH.
REQ-024 Illegal request: IDLE->RESP with RSP_ERR=1 and RSP_DATA=0; MEM_READ and MEM_WRITE are never asserted for that request.
REQ-025 Legal load: IDLE->READ->RESP; READ asserts MEM_READ for one cycle, and the extracted data is captured at the end of READ.
REQ-026 Load extract: shift right by 8*ADDR[2:0], mask to size, then sign- or zero-extend to 64 bits per REQ_SIGNED; doubleword ignores REQ_SIGNED.
REQ-027 Legal doubleword store: IDLE->WRITE->RESP; WRITE asserts MEM_WRITE for one cycle with MEM_WR_DATA=REQ_WDATA.
REQ-028 Legal sub-doubleword store uses read-modify-write: IDLE->READ->WRITE->RESP.
REQ-029 In a read-modify-write store, READ captures MEM_RD_DATA, and WRITE drives that captured word with bytes [ADDR[2:0] +: size] replaced by the low bytes of REQ_WDATA.
REQ-030 MEM_ADDR is held at the registered index for the whole transaction and is 0 in IDLE.
REQ-031 MEM_READ and MEM_WRITE are never high in the same cycle, and each is high for at most one cycle per request.
REQ-032 Latency from accept edge to first RSP_VALID cycle: error 1 cycle, load 2, doubleword store 2, sub-word store 3.
REQ-033 In RESP, RSP_VALID=1 and RSP_DATA/RSP_ERR are held stable until a posedge with RSP_READY=1, which returns the FSM to IDLE.
REQ-034 There is no pipelining: REQ_READY is 0 in every non-IDLE state, so a new request is accepted no earlier than the cycle after the response handshake.
REQ-035 RSP_DATA=0 for all stores.

Reset
REQ-036 While RST_N=0, the FSM is in IDLE and REQ_READY=1.
REQ-037 While RST_N=0, RSP_VALID, RSP_ERR, RSP_DATA, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WR_DATA and all internal registers are 0.
REQ-038 Reset asserted mid-transaction aborts it immediately: no MEM_WRITE is issued after RST_N falls, and the pending response is discarded.

Verification
REQ-039 Store doubleword addr 0x10, data 0x1122334455667788, then load doubleword addr 0x10 -> MEM_WRITE one cycle at index 2; load RSP_DATA=0x1122334455667788 two cycles after accept.
REQ-040 After REQ-039, store byte 0xAB at addr 0x13, then load doubleword 0x10 -> READ then WRITE at index 2; RSP_DATA=0x11223344AB667788.
REQ-041 Load word addr 0x14 with REQ_SIGNED=1, memory[2]=0x80000000_00000000 -> RSP_DATA=0xFFFFFFFF80000000; with REQ_SIGNED=0 -> 0x0000000080000000.
REQ-042 Load half at addr 0x11, and any access at addr 0x200 with DEPTH=64 -> RSP_ERR=1 after 1 cycle, RSP_DATA=0, no MEM strobes.
REQ-043 RSP_READY held 0 for 5 cycles -> RSP_VALID and RSP_DATA stable, REQ_READY=0 throughout; IDLE one cycle after RSP_READY=1.
REQ-044 RST_N pulsed low during READ of a byte store -> MEM_WRITE never asserts, memory unchanged, all outputs at reset values, REQ_READY=1.
